wb_writer: RTL and testbench

//  Writeback stage: the write-side master of the register file's single write port (we/waddr/wdata).

---
 rtl/wb_writer_pkg.sv | 15 +
 rtl/wb_hold_buf.sv | 79 +++++++
 rtl/wb_writer.sv | 101 ++++++++++
 tb/tb_wb_writer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_writer_pkg.sv
// Shared types and default sizes for the writeback stage and its hold buffer.
package wb_writer_pkg;

  localparam int WB_REG_W      = 32;
  localparam int WB_RADDR_W    = 5;
  localparam int WB_CNT_W      = 3;
  localparam int WB_STARVE_MAX = 4;

  // The hold buffer is either empty (accepting) or full (waiting to drain).
  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry valid/ready buffer for long-latency results, with drain/discard
// control and a saturating starvation counter that drives the stall request.
module wb_hold_buf
  import wb_writer_pkg::*;
#(
  parameter int REG_W      = WB_REG_W,
  parameter int RADDR_W    = WB_RADDR_W,
  parameter int STARVE_MAX = WB_STARVE_MAX,
  parameter int CNT_W      = WB_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [RADDR_W-1:0] i_load_addr,
  input  logic [REG_W-1:0]   i_load_data,
  input  logic               i_drain,
  input  logic               i_discard,
  output buf_state_t         o_state,
  output logic               o_valid,
  output logic [RADDR_W-1:0] o_addr,
  output logic [REG_W-1:0]   o_data,
  output logic               o_starve
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] STARVE_THR = CNT_W'(STARVE_MAX);

  buf_state_t         r_state;
  logic [RADDR_W-1:0] r_addr;
  logic [REG_W-1:0]   r_data;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_starve;
  logic [CNT_W-1:0]   w_cnt_nxt;

  assign w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= BUF_EMPTY;
      r_addr   <= '0;
      r_data   <= '0;
      r_cnt    <= '0;
      r_starve <= 1'b0;
    end else begin
      case (r_state)
        BUF_EMPTY: begin
          r_cnt    <= '0;
          r_starve <= 1'b0;
          // A result for r0 completes its handshake but is never stored.
          if (i_load && (i_load_addr != '0)) begin
            r_state <= BUF_FULL;
            r_addr  <= i_load_addr;
            r_data  <= i_load_data;
          end
        end
        BUF_FULL: begin
          if (i_drain || i_discard) begin
            r_state  <= BUF_EMPTY;
            r_addr   <= '0;
            r_data   <= '0;
            r_cnt    <= '0;
            r_starve <= 1'b0;
          end else begin
            r_cnt    <= w_cnt_nxt;
            r_starve <= (w_cnt_nxt >= STARVE_THR);
          end
        end
        default: r_state <= BUF_EMPTY;
      endcase
    end
  end

  assign o_state  = r_state;
  assign o_valid  = (r_state == BUF_FULL);
  assign o_addr   = r_addr;
  assign o_data   = r_data;
  assign o_starve = r_starve;

endmodule

// File: rtl/wb_writer.sv
// Writeback stage: drives the regfile write port, giving MEM-stage results
// priority over buffered long-latency results.
//
// Long-latency handshake: a result transfers on a rising edge where
// i_lat_valid and o_lat_ready are both high; o_lat_ready is high exactly when
// the hold buffer is empty, and the offerer must hold i_lat_* until then.
module wb_writer
  import wb_writer_pkg::*;
#(
  parameter int REG_W      = WB_REG_W,
  parameter int RADDR_W    = WB_RADDR_W,
  parameter int STARVE_MAX = WB_STARVE_MAX,
  parameter int CNT_W      = WB_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_mem_wreg,
  input  logic [RADDR_W-1:0] i_mem_waddr,
  input  logic [REG_W-1:0]   i_mem_wdata,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_lat_valid,
  input  logic [RADDR_W-1:0] i_lat_waddr,
  input  logic [REG_W-1:0]   i_lat_wdata,
  output logic               o_lat_ready,
  output logic               o_we,
  output logic [RADDR_W-1:0] o_waddr,
  output logic [REG_W-1:0]   o_wdata,
  output logic               o_pend_valid,
  output logic [RADDR_W-1:0] o_pend_addr,
  output logic               o_wb_stall_req
);

  logic               w_pipe_w;
  logic               w_load;
  logic               w_drain;
  logic               w_discard;
  buf_state_t         w_buf_state;
  logic               w_buf_valid;
  logic [RADDR_W-1:0] w_buf_addr;
  logic [REG_W-1:0]   w_buf_data;
  logic               w_starve;

  logic               r_we;
  logic [RADDR_W-1:0] r_waddr;
  logic [REG_W-1:0]   r_wdata;

  // Writes to r0 are architectural no-ops, so they never claim the port.
  assign w_pipe_w  = i_mem_wreg & ~i_stall & ~i_flush & (i_mem_waddr != '0);
  assign w_load    = i_lat_valid & o_lat_ready;
  assign w_drain   = ~w_pipe_w & w_buf_valid;
  // Younger pipeline write to the same register makes the buffered value dead.
  assign w_discard = w_pipe_w & w_buf_valid & (i_mem_waddr == w_buf_addr);

  wb_hold_buf #(
    .REG_W      (REG_W),
    .RADDR_W    (RADDR_W),
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_hold_buf (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_addr (i_lat_waddr),
    .i_load_data (i_lat_wdata),
    .i_drain     (w_drain),
    .i_discard   (w_discard),
    .o_state     (w_buf_state),
    .o_valid     (w_buf_valid),
    .o_addr      (w_buf_addr),
    .o_data      (w_buf_data),
    .o_starve    (w_starve)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_pipe_w) begin
      r_we    <= 1'b1;
      r_waddr <= i_mem_waddr;
      r_wdata <= i_mem_wdata;
    end else if (w_buf_valid) begin
      r_we    <= 1'b1;
      r_waddr <= w_buf_addr;
      r_wdata <= w_buf_data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign o_lat_ready    = (w_buf_state == BUF_EMPTY);
  assign o_we           = r_we;
  assign o_waddr        = r_waddr;
  assign o_wdata        = r_wdata;
  assign o_pend_valid   = w_buf_valid;
  assign o_pend_addr    = w_buf_addr;
  assign o_wb_stall_req = w_starve;

endmodule

// File: tb/tb_wb_writer.sv
// Directed and randomized checks of wb_writer against a queue-based model.
module tb_wb_writer;

  localparam int STARVE = 4;
  localparam int AGE_CAP = 7;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        mem_wreg;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        stall;
  logic        flush;
  logic        lat_valid;
  logic [4:0]  lat_waddr;
  logic [31:0] lat_wdata;
  logic        lat_ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        pend_valid;
  logic [4:0]  pend_addr;
  logic        wb_stall_req;

  int n_total;
  int n_pass;
  int r7_writes;

  // Reference model: the buffer is a queue of at most one pending result.
  ent_t        buf_q[$];
  int          m_age;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        m_stall;

  wb_writer dut (
    .clk            (clk),
    .rst            (rst),
    .i_mem_wreg     (mem_wreg),
    .i_mem_waddr    (mem_waddr),
    .i_mem_wdata    (mem_wdata),
    .i_stall        (stall),
    .i_flush        (flush),
    .i_lat_valid    (lat_valid),
    .i_lat_waddr    (lat_waddr),
    .i_lat_wdata    (lat_wdata),
    .o_lat_ready    (lat_ready),
    .o_we           (we),
    .o_waddr        (waddr),
    .o_wdata        (wdata),
    .o_pend_valid   (pend_valid),
    .o_pend_addr    (pend_addr),
    .o_wb_stall_req (wb_stall_req)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_step();
    bit ready;
    bit pipe;
    bit removed;
    if (rst) begin
      buf_q.delete();
      m_age = 0; m_stall = 1'b0;
      m_we = 1'b0; m_waddr = '0; m_wdata = '0;
      return;
    end
    ready   = (buf_q.size() == 0);
    pipe    = mem_wreg && !stall && !flush && (mem_waddr != 0);
    removed = 0;
    if (pipe) begin
      m_we = 1'b1; m_waddr = mem_waddr; m_wdata = mem_wdata;
      if (!ready && buf_q[0].a == mem_waddr) begin
        void'(buf_q.pop_front());
        removed = 1;
      end
    end else if (!ready) begin
      m_we = 1'b1; m_waddr = buf_q[0].a; m_wdata = buf_q[0].d;
      void'(buf_q.pop_front());
      removed = 1;
    end else begin
      m_we = 1'b0;
    end
    if (!ready && !removed) begin
      if (m_age < AGE_CAP) m_age++;
    end else begin
      m_age = 0;
    end
    m_stall = !ready && !removed && (m_age >= STARVE);
    if (ready && lat_valid && lat_waddr != 0) buf_q.push_back('{lat_waddr, lat_wdata});
  endtask

  // Driver: check ready before the edge, advance model and DUT, compare after.
  task automatic tick();
    check("lat_ready", lat_ready, (buf_q.size() == 0));
    model_step();
    @(posedge clk);
    #1;
    if (we && waddr == 5'd7) r7_writes++;
    check("we", we, m_we);
    check("waddr", waddr, m_waddr);
    check("wdata", wdata, m_wdata);
    check("pend_valid", pend_valid, (buf_q.size() != 0));
    check("pend_addr", pend_addr, (buf_q.size() != 0) ? buf_q[0].a : 5'd0);
    check("wb_stall_req", wb_stall_req, m_stall);
  endtask

  task automatic idle_inputs();
    mem_wreg = 0; mem_waddr = 0; mem_wdata = 0; stall = 0; flush = 0;
    lat_valid = 0; lat_waddr = 0; lat_wdata = 0;
  endtask

  initial begin
    n_total = 0; n_pass = 0; r7_writes = 0;
    buf_q.delete(); m_age = 0; m_stall = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
    idle_inputs();
    rst = 1;
    #1;
    tick(); tick();
    check("reset_lat_ready", lat_ready, 1);
    check("reset_we", we, 0);
    rst = 0;

    // 1: reset while holding r7
    lat_valid = 1; lat_waddr = 7; lat_wdata = 32'hAA; mem_wreg = 1; mem_waddr = 2; mem_wdata = 1;
    tick();
    check("t1_pend", pend_valid, 1);
    idle_inputs(); rst = 1;
    tick();
    check("t1_we", we, 0);
    check("t1_pend_after_rst", pend_valid, 0);
    check("t1_ready", lat_ready, 1);
    rst = 0;
    for (int i = 0; i < 3; i++) tick();
    check("t1_no_r7_write", r7_writes, 0);

    // 2: pipeline only, then r0
    mem_wreg = 1; mem_waddr = 3; mem_wdata = 32'h1234;
    tick();
    check("t2_we", we, 1); check("t2_waddr", waddr, 3); check("t2_wdata", wdata, 32'h1234);
    mem_waddr = 0; mem_wdata = 32'h9999;
    tick();
    check("t2_r0_we", we, 0);
    idle_inputs();

    // 3: idle drain
    lat_valid = 1; lat_waddr = 9; lat_wdata = 32'hDEAD;
    tick();
    check("t3_we_early", we, 0);
    lat_valid = 0;
    tick();
    check("t3_we", we, 1); check("t3_waddr", waddr, 9); check("t3_wdata", wdata, 32'hDEAD);
    check("t3_ready", lat_ready, 1);

    // 4: starvation then MEM stall lets it drain
    lat_valid = 1; lat_waddr = 5; lat_wdata = 32'h55; mem_wreg = 1; mem_waddr = 1; mem_wdata = 32'h11;
    tick();
    lat_valid = 0;
    for (int i = 0; i < 3; i++) tick();
    check("t4_no_req_yet", wb_stall_req, 0);
    tick();
    check("t4_req", wb_stall_req, 1);
    stall = 1;
    tick();
    check("t4_drain_waddr", waddr, 5); check("t4_drain_wdata", wdata, 32'h55);
    check("t4_req_clear", wb_stall_req, 0);
    idle_inputs();

    // 5: WAW, younger pipeline write wins
    lat_valid = 1; lat_waddr = 6; lat_wdata = 32'hBAD; mem_wreg = 1; mem_waddr = 2; mem_wdata = 32'h22;
    tick();
    lat_valid = 0; mem_waddr = 6; mem_wdata = 32'h66;
    tick();
    check("t5_wdata", wdata, 32'h66); check("t5_pend", pend_valid, 0);
    idle_inputs();
    tick();
    check("t5_no_stale_write", we, 0);

    // 6: back-to-back offers
    lat_valid = 1; lat_waddr = 10; lat_wdata = 32'h10;
    tick();
    lat_waddr = 11; lat_wdata = 32'h11;
    check("t6_not_ready", lat_ready, 0);
    tick();
    check("t6_first", waddr, 10);
    tick();
    lat_valid = 0;
    tick();
    check("t6_second", waddr, 11); check("t6_second_data", wdata, 32'h11);
    idle_inputs();

    // Randomized traffic; small address range so WAW collisions are common.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      mem_wreg  = $urandom_range(0, 1);
      mem_waddr = 5'($urandom_range(0, 7));
      mem_wdata = $urandom;
      stall     = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      if (!lat_valid || lat_ready) begin
        lat_valid = $urandom_range(0, 1);
        lat_waddr = 5'($urandom_range(0, 7));
        lat_wdata = $urandom;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
